// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, drives a 1-cycle-latency instruction
// memory and feeds the IF/ID register, with a 1-entry skid buffer for stalls.
module fetch_stage #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned INSTR_WIDTH = 16,
  parameter logic [WIDTH-1:0]       RESET_PC  = 16'h0000,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR = 16'h0000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [WIDTH-1:0]       redirect_pc,
  output logic                   imem_req,
  output logic [WIDTH-1:0]       imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   if_id_valid,
  output logic [INSTR_WIDTH-1:0] if_id_instr,
  output logic [WIDTH-1:0]       if_id_pc,
  output logic [WIDTH-1:0]       if_id_pc_plus1
);

  localparam logic [WIDTH-1:0] PC_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] PC_ZERO = {WIDTH{1'b0}};

  logic                   rsp_pending;
  logic [WIDTH-1:0]       rsp_pc;
  logic [WIDTH-1:0]       pc_q;
  logic                   skid_valid;
  logic [INSTR_WIDTH-1:0] skid_instr;
  logic [WIDTH-1:0]       skid_pc;

  // Issuing is suppressed whenever a stalled response would have nowhere to go.
  assign imem_req  = reset & ~redirect & ~(stall & (rsp_pending | skid_valid));
  assign imem_addr = pc_q;

  // PC, in-flight tracking, skid buffer and IF/ID pipeline register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q           <= RESET_PC;
      rsp_pending    <= 1'b0;
      rsp_pc         <= PC_ZERO;
      skid_valid     <= 1'b0;
      skid_instr     <= NOP_INSTR;
      skid_pc        <= PC_ZERO;
      if_id_valid    <= 1'b0;
      if_id_instr    <= NOP_INSTR;
      if_id_pc       <= PC_ZERO;
      if_id_pc_plus1 <= PC_ZERO;
    end else if (redirect) begin
      // Anything in flight or buffered belongs to the wrong path.
      pc_q        <= redirect_pc;
      rsp_pending <= 1'b0;
      skid_valid  <= 1'b0;
      if_id_valid <= 1'b0;
      if_id_instr <= NOP_INSTR;
    end else begin
      if (imem_req) begin
        pc_q        <= pc_q + PC_ONE;
        rsp_pending <= 1'b1;
        rsp_pc      <= pc_q;
      end else begin
        rsp_pending <= 1'b0;
      end

      if (rsp_pending) begin
        if (!stall) begin
          if_id_valid    <= 1'b1;
          if_id_instr    <= imem_rdata;
          if_id_pc       <= rsp_pc;
          if_id_pc_plus1 <= rsp_pc + PC_ONE;
        end else begin
          skid_valid <= 1'b1;
          skid_instr <= imem_rdata;
          skid_pc    <= rsp_pc;
        end
      end else if (!stall) begin
        if (skid_valid) begin
          if_id_valid    <= 1'b1;
          if_id_instr    <= skid_instr;
          if_id_pc       <= skid_pc;
          if_id_pc_plus1 <= skid_pc + PC_ONE;
          skid_valid     <= 1'b0;
        end else begin
          if_id_valid <= 1'b0;
          if_id_instr <= NOP_INSTR;
        end
      end else begin
        if_id_valid <= if_id_valid;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: startup, stall/skid, redirects, PC wrap and
// mid-stream reset, against a synchronous memory returning addr ^ 0xA000.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, redirect;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr, imem_rdata;
  logic        if_id_valid;
  logic [15:0] if_id_instr, if_id_pc, if_id_pc_plus1;

  logic        zero_stall, zero_redirect;
  logic [15:0] zero_pc;
  logic        w_req;
  logic [15:0] w_addr, w_rdata;
  logic        w_valid;
  logic [15:0] w_instr, w_pc, w_pc_plus1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
    .if_id_pc(if_id_pc), .if_id_pc_plus1(if_id_pc_plus1)
  );

  fetch_stage #(.RESET_PC(16'hFFFE)) dut_wrap (
    .clk(clk), .reset(reset), .stall(zero_stall), .redirect(zero_redirect),
    .redirect_pc(zero_pc), .imem_req(w_req), .imem_addr(w_addr),
    .imem_rdata(w_rdata), .if_id_valid(w_valid), .if_id_instr(w_instr),
    .if_id_pc(w_pc), .if_id_pc_plus1(w_pc_plus1)
  );

  // Synchronous instruction memories, one-cycle read latency
  always @(posedge clk) begin
    imem_rdata <= imem_addr ^ 16'hA000;
    w_rdata    <= w_addr ^ 16'hA000;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [15:0] pc);
    check({tag, ".valid"}, 32'(if_id_valid), 32'd1);
    check({tag, ".pc"},    32'(if_id_pc), 32'(pc));
    check({tag, ".instr"}, 32'(if_id_instr), 32'(pc ^ 16'hA000));
    check({tag, ".plus1"}, 32'(if_id_pc_plus1), 32'(pc + 16'd1));
  endtask

  task automatic expect_bubble(input string tag);
    check({tag, ".valid"}, 32'(if_id_valid), 32'd0);
    check({tag, ".instr"}, 32'(if_id_instr), 32'h0000);
  endtask

  // The skid buffer and an in-flight response must never coexist
  always @(negedge clk) begin
    if (reset === 1'b1)
      check("skid_vs_pending", 32'(dut.skid_valid & dut.rsp_pending), 32'd0);
  end

  initial begin
    reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    zero_stall = 1'b0; zero_redirect = 1'b0; zero_pc = 16'h0000;

    // Reset state
    step(); step();
    expect_bubble("rst");
    check("rst.pc", 32'(if_id_pc), 32'h0000);
    check("rst.plus1", 32'(if_id_pc_plus1), 32'h0000);
    check("rst.req", 32'(imem_req), 32'd0);
    check("rst.addr", 32'(imem_addr), 32'h0000);
    check("rst.wrap_addr", 32'(w_addr), 32'hFFFE);

    // Startup and streaming
    reset = 1'b1; #1;
    check("run.req", 32'(imem_req), 32'd1);
    step();
    check("e1.valid", 32'(if_id_valid), 32'd0);
    check("e1.addr", 32'(imem_addr), 32'h0001);
    step(); expect_out("e2", 16'h0000);
    check("wrap.e2.pc", 32'(w_pc), 32'hFFFE);
    step(); expect_out("e3", 16'h0001);
    check("wrap.e3.pc", 32'(w_pc), 32'hFFFF);
    check("wrap.e3.plus1", 32'(w_pc_plus1), 32'h0000);
    step(); expect_out("e4", 16'h0002);
    check("wrap.e4.pc", 32'(w_pc), 32'h0000);
    check("wrap.e4.plus1", 32'(w_pc_plus1), 32'h0001);

    // Stall three cycles with pc 3 in flight
    stall = 1'b1; #1;
    check("stall.req0", 32'(imem_req), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out("stall.hold", 16'h0002);
      check("stall.req", 32'(imem_req), 32'd0);
      check("stall.addr", 32'(imem_addr), 32'h0004);
    end
    stall = 1'b0; #1;
    check("release.req", 32'(imem_req), 32'd1);
    step(); expect_out("drain", 16'h0003);
    step(); expect_out("after4", 16'h0004);
    step(); expect_out("after5", 16'h0005);

    // Stall to fill the skid with pc 6, then redirect to 0x0040
    stall = 1'b1;
    step(); expect_out("fill", 16'h0005);
    redirect = 1'b1; redirect_pc = 16'h0040; #1;
    check("redir.req", 32'(imem_req), 32'd0);
    step();
    expect_bubble("redir.e0");
    redirect = 1'b0; stall = 1'b0; #1;
    check("redir.addr", 32'(imem_addr), 32'h0040);
    check("redir.req1", 32'(imem_req), 32'd1);
    step(); expect_bubble("redir.e1");
    step(); expect_out("redir.e2", 16'h0040);
    step(); expect_out("redir.e3", 16'h0041);

    // Redirect while the response for 0x0042 arrives: it must be dropped
    redirect = 1'b1; redirect_pc = 16'h0100;
    step(); expect_bubble("drop.e0");
    redirect = 1'b0;
    step(); expect_bubble("drop.e1");
    step(); expect_out("drop.e2", 16'h0100);

    // Reset mid-stream overrides stall and redirect
    reset = 1'b0; stall = 1'b1; redirect = 1'b1; redirect_pc = 16'h0200; #1;
    check("mrst.req", 32'(imem_req), 32'd0);
    step();
    expect_bubble("mrst");
    check("mrst.pc", 32'(if_id_pc), 32'h0000);
    check("mrst.addr", 32'(imem_addr), 32'h0000);
    step();
    check("mrst.req2", 32'(imem_req), 32'd0);
    reset = 1'b1; stall = 1'b0; redirect = 1'b0;
    step(); check("mrst.e1.valid", 32'(if_id_valid), 32'd0);
    step(); expect_out("mrst.e2", 16'h0000);
    step(); expect_out("mrst.e3", 16'h0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch front end of the 16-bit pipelined cpu; sits directly upstream of the decode stage and its register file.
- Owns the PC and drives the synchronous instruction memory (1-cycle read latency).
- Delivers {valid, instr, pc, pc_plus1} through the IF/ID pipeline register.
- Handles hazard-unit stalls with a 1-entry skid buffer (no lost or duplicated instructions); flushes on branch/jump redirects from EX.

Parameters:
WIDTH, 16, PC / instruction-address width (word-addressed; PC steps by 1)
INSTR_WIDTH, 16, instruction word width
RESET_PC, 0, first fetch address after reset
NOP_INSTR, 0, value driven on if_id_instr while reset or flushed

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
stall  input  1  hazard unit: hold IF/ID contents
redirect  input  1  EX-stage taken branch/jump; flush and refetch
redirect_pc  input  WIDTH  redirect target
imem_req  output  1  read strobe to instruction memory
imem_addr  output  WIDTH  read address (= pc_q)
imem_rdata  input  INSTR_WIDTH  read data, valid the cycle after the accepted request
if_id_valid  output  1  IF/ID holds a real instruction
if_id_instr  output  INSTR_WIDTH  fetched instruction
if_id_pc  output  WIDTH  address of if_id_instr
if_id_pc_plus1  output  WIDTH  if_id_pc + 1 (registered, mod 2^WIDTH)

Behaviour:
- Internal state:
  - pc_q: next address to issue.
  - rsp_pending + rsp_pc: request issued last cycle.
  - skid_valid + skid_instr + skid_pc.
  - IF/ID registers.
- Reset, sampled reset==0 at an edge:
  - pc_q=RESET_PC; rsp_pending=0; skid_valid=0.
  - if_id_valid=0, if_id_instr=NOP_INSTR, if_id_pc=0, if_id_pc_plus1=0.
  - imem_req is combinationally 0 while reset==0.
  - Reset overrides stall and redirect; mid-operation reset drops everything in flight.
- imem_req = reset & ~redirect & ~(stall & (rsp_pending | skid_valid)).
- imem_addr = pc_q.
- On request: pc_q <= pc_q+1 (0xFFFF wraps to 0x0000), rsp_pending <= 1, rsp_pc <= pc_q. Otherwise rsp_pending <= 0.
- Response handling (rsp_pending==1; imem_rdata valid this cycle):
  - stall==0: IF/ID <= {1, imem_rdata, rsp_pc, rsp_pc+1}.
  - stall==1: skid <= {1, imem_rdata, rsp_pc}; IF/ID holds.
- Stall==0, no response, skid_valid==1: IF/ID <= skid; skid_valid <= 0.
- Stall==0, neither source: IF/ID <= bubble (valid=0, instr=NOP_INSTR; pc fields hold).
- Invariant: skid_valid and rsp_pending are never both 1, because the skid fills only when imem_req==0. Verification asserts this.
- Stall==1 with no response: IF/ID and skid hold.
- Redirect, priority below reset, overrides stall:
  - pc_q <= redirect_pc; rsp_pending <= 0, so an arriving response is discarded.
  - skid_valid <= 0; if_id_valid <= 0; if_id_instr <= NOP_INSTR.
  - imem_req=0 in the redirect cycle.
  - Redirect sampled at edge E0: request for redirect_pc accepted at E1, IF/ID loaded at E2. Redirect-to-valid latency is 2 cycles, assuming stall==0 at E2.
- Steady-state throughput: 1 instruction/cycle with stall==0.
- First valid output appears 2 edges after reset release.
- Stall release with skid full: the skid drains at the release edge and a new request is issued in the same cycle. No bubble is inserted beyond the one forced by the earlier stall.
- No combinational path from imem_rdata to any output; all if_id_* are registered.

Test Plan:
- Reset low 2 cycles, then run with imem_rdata = addr ^ 0xA000, stall=0 -> if_id_valid rises at 2nd edge after release; pc sequence 0,1,2,3 on consecutive cycles; instr 0xA000,0xA001,...; pc_plus1 = pc+1.
- Stall high 3 cycles starting while a request is in flight -> skid captures it, imem_req=0 during stall, IF/ID frozen; after release pcs continue with no gap or duplicate; assert !(skid_valid & rsp_pending).
- Redirect to 0x0040 while stalled with skid full -> if_id_valid=0 next edge; skid cleared; imem_addr=0x0040 next cycle; if_id_pc=0x0040 valid at E2, followed by 0x0041.
- Redirect in the same cycle a response arrives (pc 5 pending) -> pc 5 never appears on IF/ID; next valid pc = redirect_pc.
- RESET_PC=0xFFFE -> pcs 0xFFFE, 0xFFFF, 0x0000; pc_plus1 for 0xFFFF = 0x0000.
- reset=0 mid-stream with stall=1 and redirect=1 -> at that edge all valids 0, if_id_instr=NOP_INSTR, imem_req=0 while low; after release fetch restarts at RESET_PC.
